// File: rtl/bcd_mod11_stream_pkg.sv
// Shared constants and types for the streaming BCD divisible-by-11 checker family.
package bcd_pkg;

  localparam int BCD_MOD11     = 11;
  localparam int BCD_MAX_DIGIT = 9;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_mod11_stream_if.sv
// Digit-in / result-out valid-ready streams for bcd_mod11_stream.
interface bcd_mod11_stream_if #(
  parameter int CNT_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_digit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_divisible;
  logic [3:0]       out_remainder;
  logic [CNT_W-1:0] out_count;
  logic             out_error;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_divisible, out_remainder, out_count, out_error
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_divisible, out_remainder, out_count, out_error
  );

endinterface

// File: rtl/bcd_mod11_stream_mod11_step.sv
// One Horner step mod 11: r_next = (10*r + d) mod 11 = (d - r) mod 11.
module mod11_step
  import bcd_pkg::*;
(
  input  logic [3:0] r,
  input  logic [3:0] d,
  output logic [3:0] r_next,
  output logic       bad_digit
);

  localparam logic [4:0] MOD = 5'(BCD_MOD11);

  logic [3:0] d_eff;
  logic [4:0] sum;

  always_comb begin
    bad_digit = (d > 4'(BCD_MAX_DIGIT));
    // Non-BCD digits contribute nothing to the remainder; the error flag records them.
    d_eff     = bad_digit ? 4'd0 : d;
    sum       = {1'b0, d_eff} + MOD - {1'b0, r};
    r_next    = (sum >= MOD) ? 4'(sum - MOD) : sum[3:0];
  end

endmodule

// File: rtl/bcd_mod11_stream.sv
// Serial BCD mod-11 checker: one digit per beat MSD first, one result per frame.
module bcd_mod11_stream
  import bcd_pkg::*;
#(
  parameter int MAX_DIGITS = 16,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_mod11_stream_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  state_t           state_reg;
  logic [3:0]       rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  logic [3:0]       rem_next;
  logic             bad_digit;
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_next;
  logic             err_next;
  logic             accept;

  mod11_step u_step (
    .r         (rem_reg),
    .d         (bus.in_digit),
    .r_next    (rem_next),
    .bad_digit (bad_digit)
  );

  assign bus.in_ready  = (state_reg == ACCUM);
  assign bus.out_valid = (state_reg == RESULT);
  assign accept        = bus.in_valid && (state_reg == ACCUM);

  // The counter saturates; a digit arriving once it is full marks the frame as too long.
  always_comb begin
    cnt_full = (cnt_reg == CNT_MAX);
    cnt_next = cnt_full ? cnt_reg : cnt_reg + 1'b1;
    err_next = err_reg | bad_digit | cnt_full;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= ACCUM;
      rem_reg           <= '0;
      cnt_reg           <= '0;
      err_reg           <= 1'b0;
      bus.out_divisible <= 1'b0;
      bus.out_remainder <= '0;
      bus.out_count     <= '0;
      bus.out_error     <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              state_reg         <= RESULT;
              bus.out_remainder <= rem_next;
              bus.out_count     <= cnt_next;
              bus.out_error     <= err_next;
              bus.out_divisible <= (rem_next == 4'd0) && !err_next;
              rem_reg           <= '0;
              cnt_reg           <= '0;
              err_reg           <= 1'b0;
            end else begin
              rem_reg <= rem_next;
              cnt_reg <= cnt_next;
              err_reg <= err_next;
            end
          end
        end
        RESULT: begin
          if (bus.out_ready) begin
            state_reg <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_mod11_stream.sv
// Directed bench for bcd_mod11_stream: default instance plus a MAX_DIGITS=4 instance.
module tb_bcd_mod11_stream;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_mod11_stream_if #(.CNT_W(5)) bus_a ();
  bcd_mod11_stream_if #(.CNT_W(3)) bus_b ();

  bcd_mod11_stream #(.MAX_DIGITS(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  bcd_mod11_stream #(.MAX_DIGITS(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one digit to instance a (sel=0) or b (sel=1) and wait for it to be accepted.
  task automatic send(input bit sel, input logic [3:0] d, input logic last);
    int   n;
    logic rdy;
    n = 0;
    if (sel) begin bus_b.in_valid = 1'b1; bus_b.in_digit = d; bus_b.in_last = last; end
    else     begin bus_a.in_valid = 1'b1; bus_a.in_digit = d; bus_a.in_last = last; end
    @(negedge clk);
    rdy = sel ? bus_b.in_ready : bus_a.in_ready;
    while (!rdy && n < 20) begin
      n++;
      @(negedge clk);
      rdy = sel ? bus_b.in_ready : bus_a.in_ready;
    end
    if (!rdy) chk("in_ready_timeout", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    if (sel) begin bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; end
    else     begin bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; end
  endtask

  // Called #1 after the last digit's accepting edge: result must already be valid.
  task automatic expect_result(input bit sel, input string tag, input int rem, input int cnt,
                               input int err, input int div);
    if (sel) begin
      chk({tag, "_valid"}, {31'd0, bus_b.out_valid}, 32'd1);
      chk({tag, "_rem"},   {28'd0, bus_b.out_remainder}, 32'(rem));
      chk({tag, "_cnt"},   {29'd0, bus_b.out_count}, 32'(cnt));
      chk({tag, "_err"},   {31'd0, bus_b.out_error}, 32'(err));
      chk({tag, "_div"},   {31'd0, bus_b.out_divisible}, 32'(div));
      bus_b.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_b.out_ready = 1'b0;
      chk({tag, "_released"}, {31'd0, bus_b.out_valid}, 32'd0);
    end else begin
      chk({tag, "_valid"}, {31'd0, bus_a.out_valid}, 32'd1);
      chk({tag, "_rem"},   {28'd0, bus_a.out_remainder}, 32'(rem));
      chk({tag, "_cnt"},   {27'd0, bus_a.out_count}, 32'(cnt));
      chk({tag, "_err"},   {31'd0, bus_a.out_error}, 32'(err));
      chk({tag, "_div"},   {31'd0, bus_a.out_divisible}, 32'(div));
      bus_a.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_a.out_ready = 1'b0;
      chk({tag, "_released"}, {31'd0, bus_a.out_valid}, 32'd0);
      chk({tag, "_ready_again"}, {31'd0, bus_a.in_ready}, 32'd1);
    end
    $display("frame %s done: checks=%0d failures=%0d", tag, checks, failures);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_digit = 4'd0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_digit = 4'd0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready",  {31'd0, bus_a.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    chk("rst_rem",       {28'd0, bus_a.out_remainder}, 32'd0);
    chk("rst_cnt",       {27'd0, bus_a.out_count}, 32'd0);
    chk("rst_err",       {31'd0, bus_a.out_error}, 32'd0);
    chk("rst_div",       {31'd0, bus_a.out_divisible}, 32'd0);

    // Reset mid-frame discards 1,2; 34 mod 11 = 1
    send(0, 4'd1, 1'b0);
    send(0, 4'd2, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", {31'd0, bus_a.out_valid}, 32'd0);
    send(0, 4'd3, 1'b0);
    send(0, 4'd4, 1'b1);
    expect_result(0, "v34", 1, 2, 0, 0);

    // 1001 = 91*11
    send(0, 4'd1, 1'b0);
    send(0, 4'd0, 1'b0);
    send(0, 4'd0, 1'b0);
    send(0, 4'd1, 1'b1);
    expect_result(0, "v1001", 0, 4, 0, 1);

    // 1234 mod 11 = 2, then back-pressure with a digit waiting
    send(0, 4'd1, 1'b0);
    send(0, 4'd2, 1'b0);
    send(0, 4'd3, 1'b0);
    send(0, 4'd4, 1'b1);
    bus_a.in_valid = 1'b1; bus_a.in_digit = 4'd5; bus_a.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, bus_a.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, bus_a.in_ready}, 32'd0);
      chk("bp_rem",       {28'd0, bus_a.out_remainder}, 32'd2);
      chk("bp_cnt",       {27'd0, bus_a.out_count}, 32'd4);
    end
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    expect_result(0, "v1234", 2, 4, 0, 0);

    // Single digit 0; count 1 also proves the held digit 5 was never taken
    send(0, 4'd0, 1'b1);
    expect_result(0, "v0", 0, 1, 0, 1);

    // 1,A,1: A counts as 0 -> r 1,10,2, error set
    send(0, 4'd1, 1'b0);
    send(0, 4'hA, 1'b0);
    send(0, 4'd1, 1'b1);
    expect_result(0, "vbad", 2, 3, 1, 0);

    // 16 nines: exactly MAX_DIGITS, r alternates 9,0 -> 0
    for (int i = 0; i < 16; i++) send(0, 4'd9, (i == 15));
    expect_result(0, "nines16", 0, 16, 0, 1);

    // 17 nines: too long, count saturates, r ends at 9
    for (int i = 0; i < 17; i++) send(0, 4'd9, (i == 16));
    expect_result(0, "nines17", 9, 16, 1, 0);

    // MAX_DIGITS=4 instance: five ones -> r 1,0,1,0,1, error, count 4
    for (int i = 0; i < 5; i++) send(1, 4'd1, (i == 4));
    expect_result(1, "small5", 1, 4, 1, 0);

    // Same instance at exactly its limit: 1111 = 101*11
    for (int i = 0; i < 4; i++) send(1, 4'd1, (i == 3));
    expect_result(1, "small4", 0, 4, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
